// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message schedule generator.
package sha256_pkg;

  typedef logic [0:31] word_t;
  typedef word_t [0:63] schedule_t;

  localparam int SCHED_WORDS = 64;
  localparam int BLOCK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    DONE
  } state_t;

endpackage

// File: rtl/sigma_functions.sv
// SHA-256 lower-case sigma functions used by the message schedule expansion.
package sigma_functions;
  import sha256_pkg::*;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t lower_sigma_zero(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t lower_sigma_one(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// One schedule word: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] mod 2^32.
module sha256_sched_word
  import sha256_pkg::*;
  import sigma_functions::*;
(
  input  word_t w_m2,
  input  word_t w_m7,
  input  word_t w_m15,
  input  word_t w_m16,
  output word_t w_t
);

  assign w_t = lower_sigma_one(w_m2) + w_m7 + lower_sigma_zero(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_schedule_gen.sv
// Sequential SHA-256 message schedule producer: captures a block, expands
// W[16..63] at EXPAND_PER_CYCLE words per clock, then holds the result.
//
// state  | meaning
// IDLE   | waiting for a block, block_ready high
// EXPAND | computing W[cnt .. cnt+N-1] each clock
// DONE   | schedule held, sched_valid high until sched_ready
module sha256_msg_schedule_gen
  import sha256_pkg::*;
#(
  parameter int EXPAND_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:511] block_in,
  input  logic         block_valid,
  output logic         block_ready,
  output schedule_t    message_schedule,
  output logic         sched_valid,
  input  logic         sched_ready,
  output logic         busy
);

  state_t     state;
  logic [6:0] cnt;
  schedule_t  sched;
  logic       last_step;

  logic [5:0] wr_idx [EXPAND_PER_CYCLE];
  word_t      new_w  [EXPAND_PER_CYCLE];

  // Words t-7, t-15, t-16 always come from registers; t-2 comes from the
  // adder two positions earlier in the same cycle once the chain is deep enough.
  for (genvar j = 0; j < EXPAND_PER_CYCLE; j++) begin : g_word
    word_t w_m2;
    assign wr_idx[j] = cnt[5:0] + 6'(j);
    if (j < 2) begin : g_reg
      assign w_m2 = sched[wr_idx[j] - 6'd2];
    end else begin : g_chain
      assign w_m2 = new_w[j-2];
    end
    sha256_sched_word u_word (
      .w_m2  (w_m2),
      .w_m7  (sched[wr_idx[j] - 6'd7]),
      .w_m15 (sched[wr_idx[j] - 6'd15]),
      .w_m16 (sched[wr_idx[j] - 6'd16]),
      .w_t   (new_w[j])
    );
  end

  assign last_step        = (cnt == 7'(SCHED_WORDS - EXPAND_PER_CYCLE));
  assign message_schedule = sched;
  // Qualified by rst so the handshake opens in the very first cycle after release.
  assign block_ready      = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sched       <= '0;
      sched_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (block_valid) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
              sched[i] <= block_in[32*i +: 32];
            end
            cnt   <= 7'(BLOCK_WORDS);
            busy  <= 1'b1;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          for (int j = 0; j < EXPAND_PER_CYCLE; j++) begin
            sched[wr_idx[j]] <= new_w[j];
          end
          cnt <= cnt + 7'(EXPAND_PER_CYCLE);
          if (last_step) begin
            busy        <= 1'b0;
            sched_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (sched_ready) begin
            sched_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= 7'd64);

endmodule

// File: tb/tb_sha256_msg_schedule_gen.sv
// Directed and randomized checks of the message schedule generator for N=1 and N=4.
module tb_sha256_msg_schedule_gen;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [0:511] block_in;
  logic         bv1, bv4, sr1, sr4;
  logic         br1, br4, sv1, sv4, busy1, busy4;
  schedule_t    ms1, ms4;

  int n_cmp = 0;
  int n_err = 0;
  bit use4 = 1'b0;

  logic      m_br, m_sv, m_busy;
  schedule_t m_ms;
  assign m_br   = use4 ? br4   : br1;
  assign m_sv   = use4 ? sv4   : sv1;
  assign m_busy = use4 ? busy4 : busy1;
  assign m_ms   = use4 ? ms4   : ms1;

  always #5 clk = ~clk;

  sha256_msg_schedule_gen #(.EXPAND_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .block_in(block_in), .block_valid(bv1), .block_ready(br1),
    .message_schedule(ms1), .sched_valid(sv1), .sched_ready(sr1), .busy(busy1)
  );

  sha256_msg_schedule_gen #(.EXPAND_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .block_in(block_in), .block_valid(bv4), .block_ready(br4),
    .message_schedule(ms4), .sched_valid(sv4), .sched_ready(sr4), .busy(busy4)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic schedule_t model(input logic [0:511] b);
    logic [31:0] w [64];
    schedule_t   s;
    for (int i = 0; i < 16; i++) w[i] = b[32*i +: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) s[i] = w[i];
    return s;
  endfunction

  function automatic logic [0:511] mk_block(input logic [31:0] w0, input logic [31:0] w1,
                                            input logic [31:0] w15);
    logic [0:511] b;
    b = '0;
    b[0:31]    = w0;
    b[32:63]   = w1;
    b[480:511] = w15;
    return b;
  endfunction

  function automatic logic [0:511] rand_block();
    logic [0:511] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_sched(input string name, input schedule_t act, input schedule_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      for (int i = 0; i < 64; i++) begin
        if (act[i] !== exp[i]) begin
          $display("FAIL %s: W[%0d] got 0x%08h, expected 0x%08h", name, i, act[i], exp[i]);
          break;
        end
      end
    end
  endtask

  task automatic drive_valid(input logic v);
    if (use4) bv4 = v; else bv1 = v;
  endtask

  task automatic drive_ready(input logic v);
    if (use4) sr4 = v; else sr1 = v;
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    while (!m_sv && lat < limit) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_block(input logic [0:511] blk, output int lat, output int bcnt,
                           output logic busy_done, output schedule_t got);
    int g;
    g = 0;
    while (!m_br && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    block_in = blk;
    drive_valid(1'b1);
    @(posedge clk); #1;
    drive_valid(1'b0);
    block_in = '1;
    lat  = 0;
    bcnt = 0;
    while (!m_sv && lat < 200) begin
      if (m_busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    busy_done = m_busy;
    got = m_ms;
    drive_ready(1'b1);
    @(posedge clk); #1;
    drive_ready(1'b0);
  endtask

  typedef struct {
    string        name;
    logic [0:511] blk;
    int           i0, i1, i2;
    logic [31:0]  e0, e1, e2;
  } vec_t;

  vec_t         vecs [4];
  schedule_t    got, abc_ref;
  logic [0:511] abc_blk, rb, pend;
  int           lat, bcnt;
  logic         busy_done, ok, acc, tak;
  schedule_t    q [$];
  schedule_t    snap;
  int           acc_n, rcv_n, cyc;

  initial begin
    rst = 1'b1; bv1 = 1'b0; bv4 = 1'b0; sr1 = 1'b0; sr4 = 1'b0; block_in = '0;
    abc_blk = mk_block(32'h61626380, 32'h0, 32'h00000018);
    abc_ref = model(abc_blk);

    vecs[0] = '{"abc",  abc_blk, 16, 17, 18, 32'h61626380, 32'h000F0000, 32'h7DA86405};
    vecs[1] = '{"zero", mk_block(32'h0, 32'h0, 32'h0), 16, 40, 63, 32'h0, 32'h0, 32'h0};
    vecs[2] = '{"w0_1", mk_block(32'h1, 32'h0, 32'h0), 16, 17, 18, 32'h1, 32'h0, 32'h0000A000};
    vecs[3] = '{"w1_1", mk_block(32'h0, 32'h1, 32'h0), 16, 17, 15, 32'h02004000, 32'h1, 32'h0};

    #12;
    check("rst block_ready", {31'b0, br1}, 32'd0);
    check("rst sched_valid", {31'b0, sv1}, 32'd0);
    check("rst busy", {31'b0, busy1}, 32'd0);
    check_sched("rst schedule", ms1, '0);
    rst = 1'b0;
    #1;
    check("post-rst block_ready n1", {31'b0, br1}, 32'd1);
    check("post-rst block_ready n4", {31'b0, br4}, 32'd1);
    @(posedge clk); #1;

    use4 = 1'b0;
    for (int v = 0; v < 4; v++) begin
      run_block(vecs[v].blk, lat, bcnt, busy_done, got);
      check({vecs[v].name, " latency"}, lat, 48);
      check({vecs[v].name, " busy cycles"}, bcnt, 48);
      check({vecs[v].name, " busy at done"}, {31'b0, busy_done}, 32'd0);
      check({vecs[v].name, " word a"}, got[vecs[v].i0], vecs[v].e0);
      check({vecs[v].name, " word b"}, got[vecs[v].i1], vecs[v].e1);
      check({vecs[v].name, " word c"}, got[vecs[v].i2], vecs[v].e2);
      check_sched({vecs[v].name, " schedule"}, got, model(vecs[v].blk));
    end

    // back-pressure in DONE while a new block is offered
    rb = rand_block();
    block_in = abc_blk; bv1 = 1'b1;
    @(posedge clk); #1;
    bv1 = 1'b0;
    wait_valid(60, lat);
    check("bp latency", lat, 48);
    snap = ms1;
    check_sched("bp schedule", snap, abc_ref);
    block_in = rb; bv1 = 1'b1; sr1 = 1'b0;
    ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (ms1 !== snap || br1 !== 1'b0 || sv1 !== 1'b1) ok = 1'b0;
    end
    check("bp hold stable", {31'b0, ok}, 32'd1);
    sr1 = 1'b1;
    @(posedge clk); #1;
    sr1 = 1'b0;
    check("bp valid dropped", {31'b0, sv1}, 32'd0);
    check("bp ready next", {31'b0, br1}, 32'd1);
    check("bp no overlap", {31'b0, busy1}, 32'd0);
    @(posedge clk); #1;
    bv1 = 1'b0;
    check("bp new accepted", {31'b0, busy1}, 32'd1);
    check("bp new W0", ms1[0], rb[0:31]);
    check("bp new W15", ms1[15], rb[480:511]);
    wait_valid(60, lat);
    check_sched("bp new schedule", ms1, model(rb));
    sr1 = 1'b1;
    @(posedge clk); #1;
    sr1 = 1'b0;

    // reset 20 cycles into expansion
    block_in = abc_blk; bv1 = 1'b1;
    @(posedge clk); #1;
    bv1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("mid busy", {31'b0, busy1}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid rst valid", {31'b0, sv1}, 32'd0);
    check("mid rst busy", {31'b0, busy1}, 32'd0);
    check_sched("mid rst cleared", ms1, '0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("mid rst ready", {31'b0, br1}, 32'd1);
    run_block(abc_blk, lat, bcnt, busy_done, got);
    check("after rst latency", lat, 48);
    check_sched("after rst schedule", got, abc_ref);

    // four words per cycle
    use4 = 1'b1;
    run_block(abc_blk, lat, bcnt, busy_done, got);
    check("n4 latency", lat, 12);
    check("n4 busy cycles", bcnt, 12);
    check("n4 W18", got[18], 32'h7DA86405);
    check_sched("n4 schedule", got, abc_ref);

    // randomized traffic with valid/ready gaps
    acc_n = 0; rcv_n = 0; cyc = 0;
    pend = rand_block();
    while ((acc_n < 1000 || rcv_n < 1000) && cyc < 40000) begin
      bv4 = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
      block_in = bv4 ? pend : rand_block();
      sr4 = ($urandom_range(0, 2) != 0);
      acc = bv4 && br4;
      tak = sv4 && sr4;
      if (tak) begin
        if (q.size() == 0) check("rand spurious schedule", q.size(), 1);
        else check_sched("rand schedule", ms4, q.pop_front());
        rcv_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        q.push_back(model(pend));
        acc_n++;
        pend = rand_block();
      end
    end
    bv4 = 1'b0; sr4 = 1'b0;
    check("rand accepted", acc_n, 1000);
    check("rand received", rcv_n, 1000);
    check("rand leftover", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_msg_schedule_gen.md
Name: sha256_msg_schedule_gen

Overview:
- Sequential producer of the 64-word SHA-256 message schedule that feeds the combinational compression block's `message_schedule[0:63]` input.
- Accepts one 512-bit padded message block per valid/ready handshake.
- Expands W[16..63] over multiple cycles using the lower-sigma functions.
- Presents the full schedule as a held, valid/ready-qualified array.

Parameters:
- EXPAND_PER_CYCLE, 1, number of schedule words computed per clock during expansion; legal values 1, 2, 3, 4 (must divide 48).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- block_in  input  [0:511]  padded message block; bits [0:31] = W[0], [32:63] = W[1], ..., [480:511] = W[15]
- block_valid  input  1  block_in is valid
- block_ready  output  1  block may be accepted this cycle
- message_schedule  output  [0:31] x [0:63]  W[0..63], word bit 0 = MSB
- sched_valid  output  1  message_schedule complete and stable
- sched_ready  input  1  consumer takes the schedule this cycle
- busy  output  1  expansion in progress

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, word counter=0.
  - All 64 schedule registers=0, sched_valid=0, busy=0, block_ready=0.
  - block_ready goes 1 in the first cycle with rst=0.
- States: IDLE, EXPAND, DONE.
- IDLE:
  - block_ready=1.
  - On an edge with block_valid=1: W[0..15] <= block_in words, counter <= 16, go to EXPAND.
  - block_in is not sampled at any other time.
- EXPAND:
  - block_ready=0, busy=1.
  - Each edge computes EXPAND_PER_CYCLE words, t = counter .. counter+EXPAND_PER_CYCLE-1.
  - Formula: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32, carries discarded.
  - Within one cycle, words depend on earlier words from the same cycle (t-2 can be combinationally produced); chain the adders accordingly.
  - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - counter += EXPAND_PER_CYCLE.
  - On the edge that writes W[63]: go to DONE.
- Latency: acceptance edge k -> sched_valid=1 after edge k + 48/EXPAND_PER_CYCLE (48 cycles for N=1, 12 cycles for N=4).
- DONE:
  - sched_valid=1, busy=0, block_ready=0.
  - message_schedule held bit-stable until the handshake.
  - On an edge with sched_ready=1: sched_valid <= 0, go to IDLE; block_ready=1 the following cycle.
  - No overlap: a new block is never accepted in the same cycle the schedule is taken.
- message_schedule is driven directly from the registers at all times.
  - Contents are only meaningful while sched_valid=1.
  - W[0..15] are visible from the cycle after acceptance.
- sched_ready while not in DONE: ignored.
- block_valid while not in IDLE: ignored, with no side effects.
- Reset mid-EXPAND or mid-DONE:
  - Immediate abort: sched_valid=0, all registers cleared.
  - The partially expanded block is discarded; no output is produced for it.
- Counter width 7 bits. Counter never exceeds 64; an assertion checks this.

Decomposition:
- sha256_pkg:
  - typedef `word_t` = logic [0:31].
  - typedef `schedule_t` = `word_t` [0:63].
  - constants SCHED_WORDS=64, BLOCK_WORDS=16.
  - state enum.
- sigma_functions package: reuse existing lower_sigma_zero / lower_sigma_one (add them there if absent).
- One sub-module, sha256_sched_word: combinational, inputs W[t-2], W[t-7], W[t-15], W[t-16]; output W[t].
  - Instantiated EXPAND_PER_CYCLE times and chained.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), N=1:
  - sched_valid rises exactly 48 cycles after acceptance.
  - W16=0x61626380, W17=0x000F0000, W18=0x7DA86405.
  - All 64 words match the reference model.
- All-zero block:
  - All 64 words = 0x00000000.
  - sched_valid after 48 cycles; busy=1 for exactly 48 cycles.
- Back-pressure: hold sched_ready=0 for 10 cycles in DONE while driving a new block_valid=1:
  - message_schedule stable, block_ready=0, new block not captured.
  - After sched_ready=1: block_ready=1 next cycle, new block accepted.
- Reset asserted 20 cycles into EXPAND:
  - sched_valid=0, all words 0 immediately.
  - After release, "abc" block again gives correct schedule, no stale words.
- EXPAND_PER_CYCLE=4, "abc" block:
  - sched_valid 12 cycles after acceptance.
  - Schedule identical to the N=1 result.
- Random 1000 blocks with random valid/ready gaps:
  - Every accepted block yields exactly one schedule matching the model.
  - No schedule is lost or duplicated.
